// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between the fetch and data stages.
// Data requests win by default; a waiting fetch is served after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT   = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [7:0]  dm_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        if_valid,
    output logic        dm_valid,
    output logic [31:0] if_rdata,
    output logic [7:0]  dm_rdata,
    output logic        if_stall,
    output logic        dm_stall,
    output logic        bus_err,
    output logic        err_src
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IF_ACC = 2'd1;
    localparam logic [1:0] S_DM_ACC = 2'd2;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
    localparam logic [3:0] TMO_LAST   = 4'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    logic [3:0]  tmo_q, tmo_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;

    logic in_acc;
    logic abort;
    logic finish;
    logic grant_dm;
    logic grant_if;

    always_comb begin
        in_acc   = (state_q == S_IF_ACC) || (state_q == S_DM_ACC);
        abort    = in_acc && !mem_ready && (tmo_q == TMO_LAST);
        finish   = in_acc && (mem_ready || abort);
        grant_dm = (state_q == S_IDLE) && dm_req && !(if_req && (starve_q == STARVE_MAX));
        grant_if = (state_q == S_IDLE) && if_req && !grant_dm;
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        if (grant_dm) begin
            state_d = S_DM_ACC;
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
            tmo_d   = 4'd0;
            // Only count data grants that actually made a fetch wait.
            if (if_req && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 3'd1;
            end
        end else if (grant_if) begin
            state_d  = S_IF_ACC;
            addr_d   = if_addr;
            we_d     = 1'b0;
            wdata_d  = 8'd0;
            tmo_d    = 4'd0;
            starve_d = 3'd0;
        end else if (in_acc) begin
            if (finish) begin
                state_d = S_IDLE;
            end
            if (!mem_ready) begin
                tmo_d = tmo_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            starve_q <= 3'd0;
            tmo_q    <= 4'd0;
            addr_q   <= 32'd0;
            we_q     <= 1'b0;
            wdata_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    // Outputs are gated by reset so nothing leaks out before the first reset edge.
    always_comb begin
        mem_en    = reset && in_acc;
        mem_we    = reset && we_q;
        mem_addr  = reset ? addr_q : 32'd0;
        mem_wdata = reset ? wdata_q : 8'd0;
        if_valid  = reset && (state_q == S_IF_ACC) && finish;
        dm_valid  = reset && (state_q == S_DM_ACC) && finish;
        bus_err   = reset && abort;
        err_src   = bus_err && (state_q == S_DM_ACC);
        if_rdata  = (if_valid && !bus_err) ? mem_rdata : 32'd0;
        dm_rdata  = (dm_valid && !bus_err) ? mem_rdata[7:0] : 8'd0;
        if_stall  = if_req && !if_valid;
        dm_stall  = dm_req && !dm_valid;
    end

endmodule
